// File: rtl/fill_and_pressurize.sv
// fill_and_pressurize: airlock fill-and-pressurize sequencer.
// Ports:
//   Clock       - system clock, all state updates on the rising edge
//   Reset       - synchronous active-high reset
//   begin_FandP - level-sensitive start request from the airlock controller
//   InnerClosed - 1 = inner door closed
//   OuterClosed - 1 = outer door closed
//   Pressurized - 1 = chamber pressure has reached target
//   FandP       - 1 = pump/fill in progress, decoded from registered state only
module fill_and_pressurize #(
    parameter int FILL_CYCLES = 5
) (
    input  logic Clock,
    input  logic Reset,
    input  logic begin_FandP,
    input  logic InnerClosed,
    input  logic OuterClosed,
    input  logic Pressurized,
    output logic FandP
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    localparam logic [2:0] FILL_LD = 3'(FILL_CYCLES);
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic doors_closed;
    assign doors_closed = InnerClosed & OuterClosed;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // Door abort outranks completion; Pressurized only matters once the
    // minimum fill count has run out, and the counter saturates at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (begin_FandP && doors_closed) begin
                    state_d = FILL;
                    cnt_d   = FILL_LD;
                end
            end
            FILL: begin
                if (!doors_closed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0 && Pressurized) begin
                    state_d = DONE;
                end else begin
                    cnt_d = (cnt_q != '0) ? cnt_q - 3'd1 : '0;
                end
            end
            DONE: state_d = begin_FandP ? DONE : IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
    always_comb begin
        FandP = (state_q == FILL);
    end
endmodule

// File: tb/tb_fill_and_pressurize.sv
// tb_fill_and_pressurize: directed self-checking bench for the fill sequencer.
module tb_fill_and_pressurize;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic begin_FandP = 1'b0;
    logic InnerClosed = 1'b1;
    logic OuterClosed = 1'b1;
    logic Pressurized = 1'b1;
    logic FandP, FandP0;
    int total = 0;
    int bad = 0;

    fill_and_pressurize #(.FILL_CYCLES(5)) dut (
        .Clock(Clock), .Reset(Reset), .begin_FandP(begin_FandP),
        .InnerClosed(InnerClosed), .OuterClosed(OuterClosed),
        .Pressurized(Pressurized), .FandP(FandP)
    );

    fill_and_pressurize #(.FILL_CYCLES(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .begin_FandP(begin_FandP),
        .InnerClosed(InnerClosed), .OuterClosed(OuterClosed),
        .Pressurized(Pressurized), .FandP(FandP0)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with a valid start request present
        begin_FandP = 1'b1;
        tick(); chk("rst_c1", FandP, 1'b0); chk("rst0_c1", FandP0, 1'b0);
        tick(); chk("rst_c2", FandP, 1'b0); chk("rst0_c2", FandP0, 1'b0);
        Reset = 1'b0;
        tick(); chk("rst_release", FandP, 1'b1); chk("f0_start", FandP0, 1'b1);
        // Normal fill with begin held: 6 cycles high, then DONE
        tick(); chk("norm_2", FandP, 1'b1); chk("f0_done", FandP0, 1'b0);
        for (int i = 3; i <= 6; i++) begin
            tick(); chk($sformatf("norm_%0d", i), FandP, 1'b1);
        end
        chk("f0_held", FandP0, 1'b0);
        tick(); chk("norm_end", FandP, 1'b0);
        tick(); chk("done_held1", FandP, 1'b0);
        tick(); chk("done_held2", FandP, 1'b0);
        begin_FandP = 1'b0;
        tick(); chk("done_to_idle", FandP, 1'b0);
        begin_FandP = 1'b1;
        tick(); chk("rerise", FandP, 1'b1);
        // begin dropped mid-fill does not stop it
        begin_FandP = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            tick(); chk($sformatf("drop_%0d", i), FandP, 1'b1);
        end
        tick(); chk("drop_end", FandP, 1'b0);
        tick(); chk("drop_idle", FandP, 1'b0);
        // Start request with outer door open is ignored
        OuterClosed = 1'b0;
        begin_FandP = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(); chk($sformatf("door_open_%0d", i), FandP, 1'b0);
        end
        OuterClosed = 1'b1;
        tick(); chk("door_close_start", FandP, 1'b1);
        // Abort at cnt=3
        tick(); chk("abort_cnt4", FandP, 1'b1);
        tick(); chk("abort_cnt3", FandP, 1'b1);
        InnerClosed = 1'b0;
        tick(); chk("abort_idle", FandP, 1'b0);
        tick(); chk("abort_no_start", FandP, 1'b0);
        InnerClosed = 1'b1;
        tick(); chk("abort_restart", FandP, 1'b1);
        // Abort on the completion edge must go to IDLE, not DONE
        for (int i = 2; i <= 6; i++) begin
            tick(); chk($sformatf("abc_%0d", i), FandP, 1'b1);
        end
        InnerClosed = 1'b0;
        tick(); chk("abc_abort", FandP, 1'b0);
        InnerClosed = 1'b1;
        tick(); chk("abc_was_idle", FandP, 1'b1);
        // Late pressure: fill persists past the minimum
        Pressurized = 1'b0;
        begin_FandP = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            tick(); chk($sformatf("late_%0d", i), FandP, 1'b1);
        end
        Pressurized = 1'b1;
        tick(); chk("late_done", FandP, 1'b0);
        tick(); chk("late_idle", FandP, 1'b0);
        // Reset mid-fill, then a full-length restart
        begin_FandP = 1'b1;
        tick(); chk("mid_start", FandP, 1'b1);
        tick(); chk("mid_cnt4", FandP, 1'b1);
        tick(); chk("mid_cnt3", FandP, 1'b1);
        tick(); chk("mid_cnt2", FandP, 1'b1);
        Reset = 1'b1;
        tick(); chk("mid_reset", FandP, 1'b0);
        Reset = 1'b0;
        tick(); chk("mid_restart", FandP, 1'b1);
        for (int i = 2; i <= 6; i++) begin
            tick(); chk($sformatf("mid_full_%0d", i), FandP, 1'b1);
        end
        tick(); chk("mid_full_end", FandP, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
